// File: rtl/dmem_arbiter.sv
// dmem_arbiter (rev 1.0): two-requester data-memory arbiter with lock bursts and range checking.
// Build macro DMEM_ARB_RR_EN selects round-robin for unlocked conflicts; otherwise A has fixed priority.
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        a_req,
  input  logic        a_we,
  input  logic        a_lock,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,

  input  logic        b_req,
  input  logic        b_we,
  input  logic        b_lock,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,

  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_data_out,

  output logic        err
);

  localparam logic [0:0]  IDLE      = 1'b0;
  localparam logic [0:0]  ACCESS    = 1'b1;
  localparam logic [31:0] ADDR_MASK = (ADDR_W >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << ADDR_W) - 32'd1);
  localparam logic [3:0]  CNT_MAX   = 4'(LOCK_MAX);

  logic [0:0]  state;
  logic [3:0]  lock_cnt;
  logic        owner_b;
  logic        acc_read;
  logic        acc_oor;
`ifdef DMEM_ARB_RR_EN
  logic        prio_b;
`endif

  logic        lock_a;
  logic        lock_b;
  logic        any_req;
  logic        run_active;
  logic        other_req;
  logic        win_b;
  logic        win_locked;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_oor;
  logic [3:0]  cnt_next;

  // A lock run is live while its owner keeps both req and lock high.
  always_comb begin
    lock_a     = a_req & a_lock;
    lock_b     = b_req & b_lock;
    any_req    = a_req | b_req;
    run_active = (lock_cnt != 4'd0) && (owner_b ? lock_b : lock_a);
    other_req  = owner_b ? a_req : b_req;
  end

  always_comb begin
    win_b = 1'b0;
    if (run_active) begin
      if ((lock_cnt < CNT_MAX) || !other_req) begin
        win_b = owner_b;
      end else begin
        win_b = ~owner_b;
      end
    end else if (lock_a != lock_b) begin
      win_b = lock_b;
    end else if (a_req && b_req) begin
`ifdef DMEM_ARB_RR_EN
      win_b = prio_b;
`else
      win_b = 1'b0;
`endif
    end else begin
      win_b = b_req;
    end
  end

  always_comb begin
    sel_we     = win_b ? b_we    : a_we;
    sel_addr   = win_b ? b_addr  : a_addr;
    sel_wdata  = win_b ? b_wdata : a_wdata;
    sel_oor    = |(sel_addr & ~ADDR_MASK);
    win_locked = win_b ? lock_b : lock_a;
    cnt_next   = 4'd0;
    if (win_locked) begin
      if (run_active && (win_b == owner_b)) begin
        cnt_next = (lock_cnt < CNT_MAX) ? lock_cnt + 4'd1 : CNT_MAX;
      end else begin
        cnt_next = 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state          <= IDLE;
      a_ack          <= 1'b0;
      b_ack          <= 1'b0;
      a_rvalid       <= 1'b0;
      b_rvalid       <= 1'b0;
      a_rdata        <= 32'd0;
      b_rdata        <= 32'd0;
      mem_address    <= 32'd0;
      mem_write_data <= 32'd0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      err            <= 1'b0;
      lock_cnt       <= 4'd0;
      owner_b        <= 1'b0;
      acc_read       <= 1'b0;
      acc_oor        <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      prio_b         <= 1'b0;
`endif
    end else begin
      // Read data is captured at the close of the access cycle; out-of-range reads return zero.
      a_rvalid <= (state == ACCESS) && a_ack && acc_read;
      b_rvalid <= (state == ACCESS) && b_ack && acc_read;
      if ((state == ACCESS) && acc_read) begin
        if (a_ack) begin
          a_rdata <= acc_oor ? 32'd0 : mem_data_out;
        end
        if (b_ack) begin
          b_rdata <= acc_oor ? 32'd0 : mem_data_out;
        end
      end

      if (any_req) begin
        state          <= ACCESS;
        a_ack          <= ~win_b;
        b_ack          <= win_b;
        mem_address    <= sel_addr & ADDR_MASK;
        mem_write_data <= sel_wdata;
        mem_write      <= sel_we & ~sel_oor;
        mem_read       <= ~sel_we;
        acc_read       <= ~sel_we;
        acc_oor        <= sel_oor;
        err            <= err | sel_oor;
        owner_b        <= win_b;
        lock_cnt       <= cnt_next;
`ifdef DMEM_ARB_RR_EN
        prio_b         <= ~win_b;
`endif
      end else begin
        state     <= IDLE;
        a_ack     <= 1'b0;
        b_ack     <= 1'b0;
        mem_write <= 1'b0;
        mem_read  <= 1'b0;
        acc_read  <= 1'b0;
        acc_oor   <= 1'b0;
        lock_cnt  <= 4'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter against a rule-level reference model.
`default_nettype none

module tb_dmem_arbiter;

  localparam int ADDR_W   = 5;
  localparam int LOCK_MAX = 4;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
  logic        b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic        a_ack, a_rvalid, b_ack, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_address, mem_write_data, mem_data_out;
  logic        mem_write, mem_read, err;

  dmem_arbiter #(.ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_data_out(mem_data_out),
    .err(err)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT, and the model's own copy of what it should hold.
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic        mem_init = 1'b0;
  assign mem_data_out = mem[mem_address[4:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= ref_mem[i];
    end else if (mem_write) begin
      mem[mem_address[4:0]] <= mem_write_data;
    end
  end

  int   cyc = 0;
  logic rst_at_edge = 1'b0;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst_n;
  end

  typedef struct {
    int          cyc;
    logic        who;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        wr;
    logic        rd;
    logic        err;
  } ack_t;
  typedef struct {
    int          cyc;
    logic        who;
    logic [31:0] data;
  } rv_t;

  ack_t ackq[$];
  rv_t  rvq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model state: who holds a lock run and how long, whose turn it is, sticky error.
  int   run_owner = -1;
  int   run_len   = 0;
  int   pref      = 0;
  logic m_err     = 1'b0;

  task automatic model_reset();
    run_owner = -1;
    run_len   = 0;
    pref      = 0;
    m_err     = 1'b0;
  endtask

  task automatic model_step();
    logic        rq[2];
    logic        lk[2];
    logic        run_live;
    int          w;
    logic [31:0] addr;
    logic        oor;
    int          idx;
    ack_t        ae;
    rv_t         re;
    rq[0] = a_req;  rq[1] = b_req;
    lk[0] = a_req && a_lock;  lk[1] = b_req && b_lock;
    if (!rq[0] && !rq[1]) begin
      run_owner = -1;
      run_len   = 0;
      return;
    end
    run_live = (run_owner >= 0) && lk[run_owner];
    if (run_live) begin
      if (run_len < LOCK_MAX || !rq[1 - run_owner]) w = run_owner;
      else w = 1 - run_owner;
    end else if (lk[0] != lk[1]) begin
      w = lk[1] ? 1 : 0;
    end else if (rq[0] && rq[1]) begin
      w = RR ? pref : 0;
    end else begin
      w = rq[1] ? 1 : 0;
    end
    if (lk[w]) begin
      if (run_live && run_owner == w) run_len = (run_len < LOCK_MAX) ? run_len + 1 : LOCK_MAX;
      else run_len = 1;
      run_owner = w;
    end else begin
      run_owner = -1;
      run_len   = 0;
    end
    pref = 1 - w;

    ae.who   = (w == 1);
    addr     = ae.who ? b_addr : a_addr;
    ae.we    = ae.who ? b_we : a_we;
    ae.wdata = ae.who ? b_wdata : a_wdata;
    oor      = (addr >> ADDR_W) != 32'd0;
    idx      = int'(addr % 32);
    ae.addr  = addr % 32;
    ae.wr    = ae.we && !oor;
    ae.rd    = !ae.we;
    m_err    = m_err || oor;
    ae.err   = m_err;
    ae.cyc   = cyc + 1;
    if (ae.wr) ref_mem[idx] = ae.wdata;
    ackq.push_back(ae);
    if (ae.rd) begin
      re.cyc  = cyc + 2;
      re.who  = ae.who;
      re.data = oor ? 32'd0 : ref_mem[idx];
      rvq.push_back(re);
    end
  endtask

  task automatic step(input logic ar, aw, al, input logic [31:0] aa, ad,
                      input logic br, bw, bl, input logic [31:0] ba, bd);
    a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
    if (rst_n == 1'b0) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return $urandom | 32'h0000_0100;
    return 32'($urandom_range(0, 31));
  endfunction

  task automatic rand_steps(input int n, input int preq);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 99) < preq, 1'($urandom), $urandom_range(0, 99) < 30,
           rand_addr(), $urandom,
           $urandom_range(0, 99) < preq, 1'($urandom), $urandom_range(0, 99) < 30,
           rand_addr(), $urandom);
    end
  endtask

  // Reset lands at the next edge: anything the model expected after that edge is abandoned.
  task automatic do_reset(input int n);
    rst_n = 1'b1;
    while (ackq.size() > 0 && ackq[$].cyc > cyc) void'(ackq.pop_back());
    while (rvq.size() > 0 && rvq[$].cyc > cyc) void'(rvq.pop_back());
    model_reset();
    for (int i = 0; i < n; i++) rand_steps(1, 80);
    rst_n = 1'b0;
  endtask

  // Monitor: compares DUT outputs against whatever the scoreboard says is due this cycle.
  logic [31:0] hold_a = '0, hold_b = '0;
  logic        hold_err = 1'b0;
  initial begin
    ack_t ae;
    rv_t  re;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        chk("rst a_ack", {31'd0, a_ack}, 32'd0);
        chk("rst b_ack", {31'd0, b_ack}, 32'd0);
        chk("rst a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rst b_rvalid", {31'd0, b_rvalid}, 32'd0);
        chk("rst a_rdata", a_rdata, 32'd0);
        chk("rst b_rdata", b_rdata, 32'd0);
        chk("rst mem_address", mem_address, 32'd0);
        chk("rst mem_write_data", mem_write_data, 32'd0);
        chk("rst mem_wr_rd", {30'd0, mem_write, mem_read}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        hold_a = '0;
        hold_b = '0;
        hold_err = 1'b0;
      end else begin
        chk("mem_write&mem_read", {31'd0, mem_write & mem_read}, 32'd0);
        if (ackq.size() > 0 && ackq[0].cyc == cyc) begin
          ae = ackq.pop_front();
          chk("a_ack", {31'd0, a_ack}, {31'd0, !ae.who});
          chk("b_ack", {31'd0, b_ack}, {31'd0, ae.who});
          chk("mem_address", mem_address, ae.addr);
          if (ae.we) chk("mem_write_data", mem_write_data, ae.wdata);
          chk("mem_write", {31'd0, mem_write}, {31'd0, ae.wr});
          chk("mem_read", {31'd0, mem_read}, {31'd0, ae.rd});
          hold_err = ae.err;
        end else begin
          chk("idle acks", {30'd0, a_ack, b_ack}, 32'd0);
          chk("idle mem_wr_rd", {30'd0, mem_write, mem_read}, 32'd0);
        end
        if (rvq.size() > 0 && rvq[0].cyc == cyc) begin
          re = rvq.pop_front();
          chk("a_rvalid", {31'd0, a_rvalid}, {31'd0, !re.who});
          chk("b_rvalid", {31'd0, b_rvalid}, {31'd0, re.who});
          if (re.who) hold_b = re.data;
          else hold_a = re.data;
        end else begin
          chk("idle rvalids", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        end
        chk("a_rdata", a_rdata, hold_a);
        chk("b_rdata", b_rdata, hold_b);
        chk("err", {31'd0, err}, {31'd0, hold_err});
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
    ref_mem[3] = 32'hDEAD_BEEF;
    rst_n    = 1'b1;
    mem_init = 1'b1;
    rand_steps(3, 80);
    mem_init = 1'b0;
    rst_n    = 1'b0;
    idle(1);

    // Single read of a known word.
    step(1, 0, 0, 32'd3, 32'd0, 0, 0, 0, 32'd0, 32'd0);
    idle(3);
    // Continuous contention, both writing.
    for (int i = 0; i < 10; i++)
      step(1, 1, 0, 32'($urandom_range(0, 31)), $urandom, 1, 1, 0, 32'($urandom_range(0, 31)), $urandom);
    idle(2);
    // A locked against a continuously requesting B.
    for (int i = 0; i < 12; i++)
      step(1, 1'($urandom), 1, 32'($urandom_range(0, 31)), $urandom, 1, 1, 0, 32'($urandom_range(0, 31)), $urandom);
    idle(2);
    // Out-of-range write from B.
    step(0, 0, 0, 32'd0, 32'd0, 1, 1, 0, 32'h40, 32'h55);
    idle(3);

    rand_steps(1500, 70);

    // Reset while an A read is in its access cycle.
    idle(1);
    step(1, 0, 0, 32'd5, 32'd0, 0, 0, 0, 32'd0, 32'd0);
    do_reset(2);
    idle(2);

    rand_steps(1500, 85);
    idle(4);
    chk("scoreboard drained", 32'(ackq.size() + rvq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, which sets the number of memory word-address bits forwarded.
REQ-002 SHALL have parameter LOCK_MAX, default 4, which sets the maximum number of consecutive locked grants to one requester (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-high (asserted = 1), sampled on the rising edge of clk.
REQ-005 SHALL have inputs a_req/b_req (1 bit each): access request, held until ack.
REQ-006 SHALL have inputs a_we/b_we (1 bit each): 1 = write, 0 = read.
REQ-007 SHALL have inputs a_lock/b_lock (1 bit each): request back-to-back grants.
REQ-008 SHALL have inputs a_addr/b_addr (32 bits each): word address.
REQ-009 SHALL have inputs a_wdata/b_wdata (32 bits each): write data.
REQ-010 SHALL have outputs a_ack/b_ack (1 bit each): a one-cycle pulse in the cycle the access is presented to memory.
REQ-011 SHALL have outputs a_rvalid/b_rvalid (1 bit each): a one-cycle pulse when rdata is valid.
REQ-012 SHALL have outputs a_rdata/b_rdata (32 bits each): read data.
REQ-013 SHALL have outputs mem_address (32 bits), mem_write_data (32 bits), mem_write (1 bit) and mem_read (1 bit), all registered, which drive the data memory.
REQ-014 SHALL have input mem_data_out (32 bits): combinational read data from the memory.
REQ-015 SHALL have output err (1 bit, sticky): set by an out-of-range access (see REQ-029).

Function
REQ-016 SHALL implement an FSM with states IDLE and ACCESS.
REQ-017 SHALL, in IDLE, select a winner when any req=1 and move to ACCESS on the next edge.
REQ-018 SHALL, on entry to ACCESS, register the winner's command onto the mem_* outputs.
REQ-019 SHALL, in ACCESS:
- pulse the winner's ack;
- drive mem_address = {0, addr[ADDR_W-1:0]};
- drive mem_write = we and mem_read = !we;
- never assert mem_write and mem_read together.
REQ-020 SHALL, while in ACCESS, accept a pending request directly, so that ACCESS repeats back-to-back. Throughput is one access per cycle when requests are continuous.
REQ-021 SHALL, on leaving ACCESS with no request pending, return to IDLE with mem_write = mem_read = 0.
REQ-022 SHALL, for a read, capture mem_data_out into x_rdata at the end of ACCESS, so that x_rvalid pulses the following cycle. Read latency from the ack cycle is 1.
REQ-023 SHALL hold x_rdata until the next read by the same requester.
REQ-024 SHALL NOT pulse rvalid for writes.
REQ-025 SHALL give a requester whose lock=1 and req=1 precedence over the other requester for up to LOCK_MAX consecutive grants. After that, the other requester (if req=1) wins the next grant, and the lock counter clears.
REQ-026 SHALL clear the lock counter when lock drops or the grant changes.
REQ-027 SHALL treat a requester that deasserts req before its ack as withdrawn, with no access issued.
REQ-028 SHALL give the first grant to A when both requesters request simultaneously.
REQ-029 SHALL treat an access with addr[31:ADDR_W] != 0 as out of range:
- it is still acked;
- a write is suppressed (mem_write = 0);
- a read returns 0;
- err is set.

Reset
REQ-030 SHALL, when rst_n=1 at a clock edge:
- set the FSM to IDLE;
- set all ack/rvalid = 0, mem_write = mem_read = 0, mem_address = mem_write_data = 0;
- set a_rdata = b_rdata = 0 and err = 0;
- set the lock counter = 0 and the round-robin pointer to A.
REQ-031 SHALL abandon any access in flight when reset is asserted mid-ACCESS, with no rvalid pulse after reset.
REQ-032 SHALL hold all outputs at their reset values while reset is held.

Configuration
REQ-033 SHALL use macro DMEM_ARB_RR_EN to select the arbitration policy for non-locked conflicts.
REQ-034 SHALL, when DMEM_ARB_RR_EN is defined, arbitrate non-locked conflicts round-robin: the requester not granted last wins.
REQ-035 SHALL, when DMEM_ARB_RR_EN is undefined, arbitrate non-locked conflicts with fixed priority A over B. Lock behaviour is identical in both builds.

Verification
REQ-036 SHALL cover a single read: A reads addr 3 (memory holds 0xDEADBEEF) -> a_ack in cycle 2, a_rvalid in cycle 3, a_rdata = 0xDEADBEEF, and b_ack never asserted.
REQ-037 SHALL cover contention with DMEM_ARB_RR_EN: A and B both write continuously -> grants alternate A, B, A, B; mem_write = 1 every cycle; mem_read = 0.
REQ-038 SHALL cover lock with LOCK_MAX=4: A locked and B requesting -> A gets 4 consecutive acks, then B is acked, then A resumes.
REQ-039 SHALL cover an out-of-range write: B writes 0x55 to addr 0x40 -> b_ack, mem_write = 0, err = 1 and stays 1.
REQ-040 SHALL cover reset mid-access: rst_n=1 during the ACCESS of an A read -> no a_rvalid, all outputs at reset values next cycle, and FSM in IDLE.
REQ-041 SHALL cover the fixed-priority build (DMEM_ARB_RR_EN undefined): A and B requesting continuously without lock -> only A is acked.
